// File: rtl/game_state_ctl_if.sv
// Bundles the game sequencer's input events and registered status outputs.
// slave = sequencer side, master = side driving mouse/vsync/hit inputs.
interface game_state_ctl_if;
  localparam int unsigned POS_W    = 12;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned FRAMES_W = 11;

  logic                vsync_in;
  logic                mouse_left;
  logic [POS_W-1:0]    mouse_xpos;
  logic [POS_W-1:0]    mouse_ypos;
  logic                btn_menu;
  logic                player_hit;
  logic                peer_ready;
  logic [STATE_W-1:0]  control_state;
  logic [LIVES_W-1:0]  lives_left;
  logic [FRAMES_W-1:0] frames_left;
  logic                game_rst;
  logic                local_ready;

  modport master (
    output vsync_in, mouse_left, mouse_xpos, mouse_ypos,
    output btn_menu, player_hit, peer_ready,
    input  control_state, lives_left, frames_left, game_rst, local_ready
  );

  modport slave (
    input  vsync_in, mouse_left, mouse_xpos, mouse_ypos,
    input  btn_menu, player_hit, peer_ready,
    output control_state, lives_left, frames_left, game_rst, local_ready
  );
endinterface

// File: rtl/game_state_ctl.sv
// Game sequencer: MENU/GAME/VICTORY/GAME_OVER/MULTI_WAIT, lives and survival-frame counters.
// Define MULTIPLAYER_EN to enable the MULTI button, MULTI_WAIT state and local_ready.
module game_state_ctl #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned GAME_FRAMES   = 1800,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BTN_X0        = 412,
  parameter int unsigned BTN_X1        = 612,
  parameter int unsigned PLAY_Y0       = 400,
  parameter int unsigned PLAY_Y1       = 480,
  parameter int unsigned MULTI_Y0      = 500,
  parameter int unsigned MULTI_Y1      = 580
) (
  input logic             clk,
  input logic             rst,
  game_state_ctl_if.slave bus
);

  localparam int unsigned POS_W    = 12;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned FRAMES_W = 11;
  localparam int unsigned INV_W    = 8;

  typedef enum logic [2:0] {
    ST_MENU       = 3'b000,
    ST_GAME       = 3'b001,
    ST_VICTORY    = 3'b010,
    ST_GAME_OVER  = 3'b011,
    ST_MULTI_WAIT = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [INV_W-1:0]    inv_q, inv_d;
  logic                game_rst_q, game_rst_d;
  logic                local_ready_q, local_ready_d;
  logic                mouse_left_q, btn_menu_q, vsync_q;

  logic click_c, menu_c, tick_c;
  logic in_play_c, in_multi_c;
  logic hit_ok_c, fatal_c, start_game_c;

  // Rising-edge events; previous samples reset high so held inputs stay quiet
  assign click_c = bus.mouse_left & ~mouse_left_q;
  assign menu_c  = bus.btn_menu   & ~btn_menu_q;
  assign tick_c  = bus.vsync_in   & ~vsync_q;

  assign in_play_c  = (bus.mouse_xpos >= POS_W'(BTN_X0))   && (bus.mouse_xpos < POS_W'(BTN_X1)) &&
                      (bus.mouse_ypos >= POS_W'(PLAY_Y0))  && (bus.mouse_ypos < POS_W'(PLAY_Y1));
  assign in_multi_c = (bus.mouse_xpos >= POS_W'(BTN_X0))   && (bus.mouse_xpos < POS_W'(BTN_X1)) &&
                      (bus.mouse_ypos >= POS_W'(MULTI_Y0)) && (bus.mouse_ypos < POS_W'(MULTI_Y1));

  // A hit only counts once the invulnerability window has drained
  assign hit_ok_c = bus.player_hit && (inv_q == '0);
  assign fatal_c  = hit_ok_c && (lives_q == LIVES_W'(1));

`ifndef MULTIPLAYER_EN
  logic unused_mp;
  assign unused_mp = bus.peer_ready ^ in_multi_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_MENU;
      lives_q       <= '0;
      frames_q      <= '0;
      inv_q         <= '0;
      game_rst_q    <= 1'b0;
      local_ready_q <= 1'b0;
      mouse_left_q  <= 1'b1;
      btn_menu_q    <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      frames_q      <= frames_d;
      inv_q         <= inv_d;
      game_rst_q    <= game_rst_d;
      local_ready_q <= local_ready_d;
      mouse_left_q  <= bus.mouse_left;
      btn_menu_q    <= bus.btn_menu;
      vsync_q       <= bus.vsync_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    frames_d     = frames_q;
    inv_d        = inv_q;
    game_rst_d   = 1'b0;
    start_game_c = 1'b0;

    if (menu_c) begin
      state_d = ST_MENU;
    end else begin
      unique case (state_q)
        ST_MENU: begin
          if (click_c && in_play_c) begin
            start_game_c = 1'b1;
`ifdef MULTIPLAYER_EN
          end else if (click_c && in_multi_c) begin
            state_d = ST_MULTI_WAIT;
`endif
          end
        end

        ST_MULTI_WAIT: begin
`ifdef MULTIPLAYER_EN
          if (bus.peer_ready) start_game_c = 1'b1;
`else
          state_d = ST_MENU;
`endif
        end

        ST_GAME: begin
          if (tick_c) begin
            if (frames_q != '0) frames_d = frames_q - FRAMES_W'(1);
            if (inv_q != '0)    inv_d    = inv_q - INV_W'(1);
          end
          if (hit_ok_c) begin
            if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            inv_d = INV_W'(INVULN_FRAMES);
          end
          // Losing the last life beats running out the clock in the same cycle
          if (fatal_c) begin
            state_d = ST_GAME_OVER;
          end else if (tick_c && (frames_q == FRAMES_W'(1))) begin
            state_d = ST_VICTORY;
          end
        end

        ST_VICTORY, ST_GAME_OVER: begin
          if (click_c) begin
            if (in_play_c) start_game_c = 1'b1;
            else           state_d      = ST_MENU;
          end
        end

        default: state_d = ST_MENU;
      endcase
    end

    if (start_game_c) begin
      state_d    = ST_GAME;
      lives_d    = LIVES_W'(LIVES);
      frames_d   = FRAMES_W'(GAME_FRAMES);
      inv_d      = '0;
      game_rst_d = 1'b1;
    end
  end

`ifdef MULTIPLAYER_EN
  assign local_ready_d = (state_d == ST_MULTI_WAIT);
`else
  assign local_ready_d = 1'b0;
`endif

  assign bus.control_state = state_q;
  assign bus.lives_left    = lives_q;
  assign bus.frames_left   = frames_q;
  assign bus.game_rst      = game_rst_q;
  assign bus.local_ready   = local_ready_q;

endmodule
